// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : 640x480@60 timing constants and lock-state type shared by the
//               VGA sync decoder and its sub-blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int VGA_H_VISIBLE   = 640;
    localparam int VGA_H_FP        = 16;
    localparam int VGA_H_SYNC      = 96;
    localparam int VGA_H_BP        = 48;
    localparam int VGA_V_VISIBLE   = 480;
    localparam int VGA_V_FP        = 10;
    localparam int VGA_V_SYNC      = 2;
    localparam int VGA_V_BP        = 33;
    localparam int VGA_H_TOTAL     = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL     = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam bit VGA_SYNC_ACTIVE = 1'b0;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } vga_lock_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : vga_edge_detect
// Description : Registered assertion-edge detector for a sync line, sampling
//               only on pixel-clock enable cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_edge_detect #(
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input  logic clk_50,
    input  logic reset,
    input  logic i_pix_en,
    input  logic i_sync,
    output logic o_edge
);

    logic r_prev;
    logic r_edge;

    // o_edge is a one-cycle pulse aligned with the registered sample
    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_prev <= ~SYNC_ACTIVE;
            r_edge <= 1'b0;
        end else begin
            r_edge <= 1'b0;
            if (i_pix_en) begin
                r_prev <= i_sync;
                r_edge <= (r_prev != SYNC_ACTIVE) && (i_sync == SYNC_ACTIVE);
            end
        end
    end

    assign o_edge = r_edge;

endmodule
`default_nettype wire

// File: rtl/vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_decoder
// Description : Locks to an incoming VGA HS/VS stream, rebuilds pixel
//               coordinates with a valid strobe and flags line/frame errors.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE   = VGA_H_VISIBLE,
    parameter int H_FP        = VGA_H_FP,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BP        = VGA_H_BP,
    parameter int V_VISIBLE   = VGA_V_VISIBLE,
    parameter int V_FP        = VGA_V_FP,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BP        = VGA_V_BP,
    parameter bit SYNC_ACTIVE = VGA_SYNC_ACTIVE
) (
    input  logic        clk_50,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic [11:0] vga_rgb,
    output logic [9:0]  x_out,
    output logic [9:0]  y_out,
    output logic [11:0] rgb_out,
    output logic        pix_valid,
    output logic        frame_start,
    output logic        locked,
    output logic        h_err,
    output logic        v_err,
    output logic [15:0] frame_cnt
);

    localparam int         c_h_total  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int         c_v_total  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] c_h_last   = 10'(c_h_total - 1);
    localparam logic [9:0] c_v_last   = 10'(c_v_total - 1);
    localparam logic [9:0] c_h_act_lo = 10'(H_SYNC + H_BP);
    localparam logic [9:0] c_h_act_hi = 10'(H_SYNC + H_BP + H_VISIBLE - 1);
    localparam logic [9:0] c_v_act_lo = 10'(V_SYNC + V_BP);
    localparam logic [9:0] c_v_act_hi = 10'(V_SYNC + V_BP + V_VISIBLE - 1);

    logic            w_hs_edge;
    logic            w_vs_edge;
    logic            r_smp_valid;
    logic [11:0]     r_smp_rgb;
    logic [9:0]      r_h_cnt;
    logic [9:0]      r_v_cnt;
    logic            r_vs_pend;
    logic            r_good;
    vga_lock_state_t r_state;
    logic [9:0]      r_x;
    logic [9:0]      r_y;
    logic [11:0]     r_rgb;
    logic            r_pix_valid;
    logic            r_frame_start;
    logic            r_locked;
    logic            r_h_err;
    logic            r_v_err;
    logic [15:0]     r_frame_cnt;

    logic            w_hs;
    logic            w_vs;
    logic            w_wrap;
    logic [9:0]      w_h_idx;
    logic [9:0]      w_v_idx;
    logic            w_active;
    logic [9:0]      w_x;
    logic [9:0]      w_y;
    logic            w_h_err;
    logic            w_v_err;
    vga_lock_state_t w_state_nxt;
    logic            w_good_nxt;

    vga_edge_detect #(.SYNC_ACTIVE(SYNC_ACTIVE)) u_hs_edge (
        .clk_50   (clk_50),
        .reset    (reset),
        .i_pix_en (pix_en),
        .i_sync   (vga_hs),
        .o_edge   (w_hs_edge)
    );

    vga_edge_detect #(.SYNC_ACTIVE(SYNC_ACTIVE)) u_vs_edge (
        .clk_50   (clk_50),
        .reset    (reset),
        .i_pix_en (pix_en),
        .i_sync   (vga_vs),
        .o_edge   (w_vs_edge)
    );

    // Indices below describe the sample held in r_smp_* (taken one cycle ago)
    always_comb begin
        w_hs    = r_smp_valid && w_hs_edge;
        w_vs    = r_smp_valid && w_vs_edge;
        w_wrap  = w_hs && (r_vs_pend || w_vs);
        w_h_idx = w_hs ? 10'd0 : r_h_cnt + 10'd1;
        if (w_wrap)
            w_v_idx = 10'd0;
        else if (w_hs)
            w_v_idx = r_v_cnt + 10'd1;
        else
            w_v_idx = r_v_cnt;
        w_active = (w_h_idx >= c_h_act_lo) && (w_h_idx <= c_h_act_hi) &&
                   (w_v_idx >= c_v_act_lo) && (w_v_idx <= c_v_act_hi);
        w_x      = w_h_idx - c_h_act_lo;
        w_y      = w_v_idx - c_v_act_lo;

        w_h_err = 1'b0;
        w_v_err = 1'b0;
        if (r_smp_valid && (r_state == LOCKED)) begin
            w_h_err = (w_hs && (r_h_cnt != c_h_last)) || (!w_hs && (r_h_cnt == c_h_last));
            w_v_err = (w_wrap && (r_v_cnt != c_v_last)) ||
                      (w_hs && !w_wrap && (r_v_cnt == c_v_last));
        end

        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        if (r_smp_valid) begin
            case (r_state)
                SEARCH: begin
                    w_good_nxt = 1'b0;
                    if (w_vs) begin
                        w_state_nxt = ALIGN;
                        w_good_nxt  = 1'b1;
                    end
                end
                ALIGN: begin
                    if (w_hs && (r_h_cnt != c_h_last))
                        w_good_nxt = 1'b0;
                    if (w_wrap) begin
                        if (w_good_nxt && (r_v_cnt == c_v_last))
                            w_state_nxt = LOCKED;
                        w_good_nxt = 1'b1;
                    end
                end
                LOCKED: begin
                    if (w_h_err || w_v_err)
                        w_state_nxt = SEARCH;
                end
                default: w_state_nxt = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_smp_valid   <= 1'b0;
            r_smp_rgb     <= 12'd0;
            r_h_cnt       <= 10'd0;
            r_v_cnt       <= 10'd0;
            r_vs_pend     <= 1'b0;
            r_good        <= 1'b0;
            r_state       <= SEARCH;
            r_x           <= 10'd0;
            r_y           <= 10'd0;
            r_rgb         <= 12'd0;
            r_pix_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_locked      <= 1'b0;
            r_h_err       <= 1'b0;
            r_v_err       <= 1'b0;
            r_frame_cnt   <= 16'd0;
        end else begin
            r_smp_valid   <= pix_en;
            if (pix_en)
                r_smp_rgb <= vga_rgb;
            r_pix_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_h_err       <= w_h_err;
            r_v_err       <= w_v_err;
            r_locked      <= (w_state_nxt == LOCKED);
            if (r_smp_valid) begin
                r_h_cnt <= w_h_idx;
                r_v_cnt <= w_v_idx;
                r_state <= w_state_nxt;
                r_good  <= w_good_nxt;
                if (w_wrap)
                    r_vs_pend <= 1'b0;
                else if (w_vs)
                    r_vs_pend <= 1'b1;
                // Gate on the next state so an erroring sample never emits a pixel
                if ((w_state_nxt == LOCKED) && w_active) begin
                    r_pix_valid <= 1'b1;
                    r_x         <= w_x;
                    r_y         <= w_y;
                    r_rgb       <= r_smp_rgb;
                    if ((w_x == 10'd0) && (w_y == 10'd0)) begin
                        r_frame_start <= 1'b1;
                        r_frame_cnt   <= r_frame_cnt + 16'd1;
                    end
                end
            end
        end
    end

    assign x_out       = r_x;
    assign y_out       = r_y;
    assign rgb_out     = r_rgb;
    assign pix_valid   = r_pix_valid;
    assign frame_start = r_frame_start;
    assign locked      = r_locked;
    assign h_err       = r_h_err;
    assign v_err       = r_v_err;
    assign frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync_decoder
// Description : Directed bench for vga_sync_decoder using a reduced raster
//               (25x11 total, 16x6 visible) so whole frames stay short.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_decoder;

    localparam int H_VIS = 16, H_FP = 2, H_SYNC = 4, H_BP = 3;
    localparam int V_VIS = 6,  V_FP = 1, V_SYNC = 2, V_BP = 2;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;   // 25
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;   // 11
    localparam int H_LO = H_SYNC + H_BP, H_HI = H_LO + H_VIS - 1;   // 7..22
    localparam int V_LO = V_SYNC + V_BP, V_HI = V_LO + V_VIS - 1;   // 4..9

    logic        clk_50 = 1'b0;
    logic        reset  = 1'b1;
    logic        pix_en = 1'b0;
    logic        vga_hs = 1'b1;
    logic        vga_vs = 1'b1;
    logic [11:0] vga_rgb = 12'd0;
    logic [9:0]  x_out, y_out;
    logic [11:0] rgb_out;
    logic        pix_valid, frame_start, locked, h_err, v_err;
    logic [15:0] frame_cnt;

    int vectors = 0, miscompares = 0;
    int g_h = 0, g_v = 0;
    int mon_valid = 0, mon_bad = 0, mon_fs = 0, mon_herr = 0, mon_verr = 0;

    vga_sync_decoder #(
        .H_VISIBLE(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VISIBLE(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_ACTIVE(1'b0)
    ) dut (
        .clk_50(clk_50), .reset(reset), .pix_en(pix_en),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_rgb(vga_rgb),
        .x_out(x_out), .y_out(y_out), .rgb_out(rgb_out),
        .pix_valid(pix_valid), .frame_start(frame_start), .locked(locked),
        .h_err(h_err), .v_err(v_err), .frame_cnt(frame_cnt)
    );

    always #10 clk_50 = ~clk_50;

    // Tracks every output pixel against the generator position that produced it
    always @(posedge clk_50) begin
        int ex, ey;
        logic [9:0] exv, eyv;
        #1;
        ex = g_h - H_LO;
        ey = g_v - V_LO;
        exv = 10'(ex);
        eyv = 10'(ey);
        if (pix_valid) begin
            mon_valid++;
            if (g_h < H_LO || g_h > H_HI || g_v < V_LO || g_v > V_HI ||
                x_out !== exv || y_out !== eyv || rgb_out !== {eyv[3:0], exv[7:0]})
                mon_bad++;
            if (frame_start !== (ex == 0 && ey == 0))
                mon_bad++;
        end else if (frame_start) begin
            mon_bad++;
        end
        if (frame_start) mon_fs++;
        if (h_err) mon_herr++;
        if (v_err) mon_verr++;
    end

    task automatic drive_pix(input int h, input int v, input bit hs_off);
        logic [9:0] xv, yv;
        @(negedge clk_50);
        g_h = h;
        g_v = v;
        xv = 10'(h - H_LO);
        yv = 10'(v - V_LO);
        vga_hs  = (h < H_SYNC && !hs_off) ? 1'b0 : 1'b1;
        vga_vs  = (v < V_SYNC) ? 1'b0 : 1'b1;
        vga_rgb = (h >= H_LO && h <= H_HI && v >= V_LO && v <= V_HI) ?
                  {yv[3:0], xv[7:0]} : 12'h000;
        pix_en = 1'b1;
        @(negedge clk_50);
        pix_en = 1'b0;
    endtask

    // Lines v0..v_stop-1, first line starting at h0; line short_v is one pixel short
    task automatic drive_lines(input int v0, input int h0, input int v_stop, input int short_v);
        int len;
        for (int v = v0; v < v_stop; v++) begin
            len = (v == short_v) ? H_TOTAL - 1 : H_TOTAL;
            for (int h = (v == v0) ? h0 : 0; h < len; h++)
                drive_pix(h, v, 1'b0);
        end
    endtask

    task automatic flush();
        repeat (2) @(posedge clk_50);
        #2;
    endtask

    task automatic clear_mon();
        mon_valid = 0; mon_bad = 0; mon_fs = 0; mon_herr = 0; mon_verr = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(posedge clk_50);
        #1;
        vectors++;
        if ({x_out, y_out, rgb_out} !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_data: got x=%0d y=%0d rgb=%h expected 0/0/000", x_out, y_out, rgb_out);
        end
        vectors++;
        if ({pix_valid, frame_start, locked, h_err, v_err} !== 5'd0 || frame_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_flags: got flags=%b cnt=%0d expected 00000/0",
                     {pix_valid, frame_start, locked, h_err, v_err}, frame_cnt);
        end
        @(negedge clk_50);
        reset = 1'b0;
    endtask

    // Shared by first lock and post-reset relock: ALIGN frame, then lock on next frame start
    task automatic test_lock(input string tag);
        drive_lines(0, 0, V_TOTAL, -1);
        flush();
        vectors++;
        if (locked !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_early: locked=%b expected 0", tag, locked);
        end
        clear_mon();
        drive_pix(0, 0, 1'b0);
        @(posedge clk_50);
        #1;
        vectors++;
        if (locked !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_rise: locked=%b expected 1", tag, locked);
        end
        drive_lines(0, 1, V_TOTAL, -1);
        flush();
        vectors++;
        if (mon_valid !== H_VIS * V_VIS || mon_fs !== 1 || mon_bad !== 0) begin
            miscompares++;
            $display("FAIL %s_frame: valid=%0d fs=%0d bad=%0d expected %0d/1/0",
                     tag, mon_valid, mon_fs, mon_bad, H_VIS * V_VIS);
        end
        vectors++;
        if (frame_cnt !== 16'd1 || mon_herr !== 0 || mon_verr !== 0) begin
            miscompares++;
            $display("FAIL %s_count: frame_cnt=%0d herr=%0d verr=%0d expected 1/0/0",
                     tag, frame_cnt, mon_herr, mon_verr);
        end
    endtask

    task automatic test_rgb_tracking();
        clear_mon();
        drive_lines(0, 0, V_TOTAL, -1);
        flush();
        vectors++;
        if (mon_bad !== 0 || mon_valid !== 96 || frame_cnt !== 16'd2) begin
            miscompares++;
            $display("FAIL rgb_frame: bad=%0d valid=%0d cnt=%0d expected 0/96/2", mon_bad, mon_valid, frame_cnt);
        end
        vectors++;
        if (x_out !== 10'd15 || y_out !== 10'd5 || rgb_out !== 12'h50F || pix_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rgb_hold: x=%0d y=%0d rgb=%h pv=%b expected 15/5/50f/0", x_out, y_out, rgb_out, pix_valid);
        end
    endtask

    task automatic test_short_line();
        clear_mon();
        drive_lines(0, 0, V_TOTAL, 5);
        flush();
        vectors++;
        if (mon_herr !== 1 || mon_verr !== 0 || locked !== 1'b0) begin
            miscompares++;
            $display("FAIL short_err: herr=%0d verr=%0d locked=%b expected 1/0/0", mon_herr, mon_verr, locked);
        end
        vectors++;
        if (mon_valid !== 32 || frame_cnt !== 16'd3 || mon_bad !== 0) begin
            miscompares++;
            $display("FAIL short_pix: valid=%0d cnt=%0d bad=%0d expected 32/3/0", mon_valid, frame_cnt, mon_bad);
        end
        drive_lines(0, 0, V_TOTAL, -1);
        flush();
        vectors++;
        if (locked !== 1'b0 || mon_valid !== 32) begin
            miscompares++;
            $display("FAIL short_align: locked=%b valid=%0d expected 0/32", locked, mon_valid);
        end
        drive_pix(0, 0, 1'b0);
        @(posedge clk_50);
        #1;
        vectors++;
        if (locked !== 1'b1) begin
            miscompares++;
            $display("FAIL short_relock: locked=%b expected 1", locked);
        end
        drive_lines(0, 1, V_TOTAL, -1);
    endtask

    task automatic test_long_frame();
        clear_mon();
        drive_lines(0, 0, V_TOTAL + 1, -1);
        flush();
        vectors++;
        if (mon_verr !== 1 || mon_herr !== 0 || locked !== 1'b0) begin
            miscompares++;
            $display("FAIL long_err: verr=%0d herr=%0d locked=%b expected 1/0/0", mon_verr, mon_herr, locked);
        end
        vectors++;
        if (mon_valid !== 96 || frame_cnt !== 16'd5) begin
            miscompares++;
            $display("FAIL long_pix: valid=%0d cnt=%0d expected 96/5", mon_valid, frame_cnt);
        end
        drive_lines(0, 0, V_TOTAL, -1);
        flush();
        vectors++;
        if (mon_verr !== 1 || locked !== 1'b0) begin
            miscompares++;
            $display("FAIL long_search: verr=%0d locked=%b expected 1/0", mon_verr, locked);
        end
    endtask

    task automatic test_hs_missing();
        drive_lines(0, 0, V_TOTAL, -1);
        flush();
        vectors++;
        if (locked !== 1'b1) begin
            miscompares++;
            $display("FAIL hs_prelock: locked=%b expected 1", locked);
        end
        clear_mon();
        drive_lines(0, 0, 3, -1);
        drive_pix(0, 3, 1'b1);
        @(posedge clk_50);
        #1;
        vectors++;
        if (h_err !== 1'b1) begin
            miscompares++;
            $display("FAIL hs_missing_pulse: h_err=%b expected 1", h_err);
        end
        for (int h = 1; h < 40; h++)
            drive_pix(h, 3, 1'b1);
        drive_lines(0, 0, V_TOTAL, -1);
        flush();
        vectors++;
        if (mon_herr !== 1 || locked !== 1'b0 || mon_valid !== 0) begin
            miscompares++;
            $display("FAIL hs_missing_after: herr=%0d locked=%b valid=%0d expected 1/0/0", mon_herr, locked, mon_valid);
        end
    endtask

    task automatic test_reset_mid_frame();
        drive_lines(0, 0, 7, -1);
        for (int h = 0; h <= 17; h++)
            drive_pix(h, 7, 1'b0);
        @(posedge clk_50);
        #1;
        vectors++;
        if (pix_valid !== 1'b1 || x_out !== 10'd10 || y_out !== 10'd3 || locked !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pixel: pv=%b x=%0d y=%0d locked=%b expected 1/10/3/1", pix_valid, x_out, y_out, locked);
        end
        @(negedge clk_50);
        reset = 1'b1;
        @(posedge clk_50);
        #1;
        vectors++;
        if ({x_out, y_out, rgb_out} !== 32'd0 || {pix_valid, frame_start, locked, h_err, v_err} !== 5'd0 ||
            frame_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL mid_reset: x=%0d y=%0d rgb=%h flags=%b cnt=%0d expected all 0", x_out, y_out, rgb_out,
                     {pix_valid, frame_start, locked, h_err, v_err}, frame_cnt);
        end
        @(negedge clk_50);
        reset = 1'b0;
        clear_mon();
        drive_lines(7, 18, V_TOTAL, -1);
        flush();
        vectors++;
        if (locked !== 1'b0 || mon_valid !== 0) begin
            miscompares++;
            $display("FAIL mid_tail: locked=%b valid=%0d expected 0/0", locked, mon_valid);
        end
        test_lock("relock");
    endtask

    initial begin
        test_reset();
        test_lock("lock");
        test_rgb_tracking();
        test_short_line();
        test_long_frame();
        test_hs_missing();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the VGA display driver. Samples the 640x480@60 VGA stream (HS, VS, 12-bit RGB) at the pixel-clock rate, locks to its sync timing, and reconstructs pixel coordinates with a valid strobe. It also checks the stream's line and frame lengths. It sits in the self-check path, on the same board as the game top-level, listening to the driver's output pins, and feeds a frame checker or capture logic.

## Interface
- H_VISIBLE, 640, active pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porches and sync width (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porches and sync width (lines)
- SYNC_ACTIVE, 0, level of HS/VS while asserted (0 = active-low)
- clk_50  in  1  system clock, 50 MHz; one clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- pix_en  in  1  pixel-clock enable, one clk_50 cycle in two; inputs sampled only when high
- vga_hs  in  1  horizontal sync
- vga_vs  in  1  vertical sync
- vga_rgb  in  12  pixel colour as driven to the DAC
- x_out  out  10  column of the output pixel, 0..H_VISIBLE-1
- y_out  out  10  row of the output pixel, 0..V_VISIBLE-1
- rgb_out  out  12  vga_rgb registered with x_out/y_out
- pix_valid  out  1  x_out/y_out/rgb_out describe an active pixel
- frame_start  out  1  one-cycle pulse with pixel (0,0)
- locked  out  1  timing lock established
- h_err  out  1  one-cycle pulse on a line-length violation while locked
- v_err  out  1  one-cycle pulse on a frame-length violation while locked
- frame_cnt  out  16  count of frame_start pulses, wraps

## Operation
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800). V_TOTAL analogous (525). Counters are 10 bits.
- Edge detect on samples with pix_en=1. An HS edge is a previous sample not equal to SYNC_ACTIVE followed by a current sample equal to SYNC_ACTIVE. VS edge is defined the same way.
- h_cnt: set to 0 on an HS edge, otherwise +1 per sample. Index 0 is the first sync pixel.
  - Active region: h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_VISIBLE-1].
  - x = h_cnt-(H_SYNC+H_BP).
- v_cnt: +1 on each HS edge.
  - A VS edge sets vs_pend. The next HS edge (or the same sample, if coincident) sets v_cnt to 0 and clears vs_pend.
  - Active rows: v_cnt in [V_SYNC+V_BP, +V_VISIBLE-1].
  - y = v_cnt-(V_SYNC+V_BP).
- FSM states:
  - SEARCH: a VS edge moves to ALIGN. Clear the line-good flag.
  - ALIGN: measure one frame. Every HS edge must arrive at h_cnt==H_TOTAL-1; otherwise clear the good flag. At the next frame wrap (v_cnt reset):
    - If good and the previous v_cnt==V_TOTAL-1, go to LOCKED.
    - Otherwise stay in ALIGN and re-arm the good flag.
  - LOCKED: check timing continuously.
    - HS edge with h_cnt != H_TOTAL-1 → h_err.
    - h_cnt reaches H_TOTAL-1 and the next sample has no HS edge → h_err (missing sync).
    - Frame wrap with v_cnt != V_TOTAL-1, or v_cnt passing V_TOTAL-1 → v_err.
    - Any error → SEARCH.
- h_err and v_err on the same sample: both pulse; a single transition to SEARCH.
- pix_valid=1 only in LOCKED, in the active region, on the cycle following a pix_en sample. It is 0 on all other cycles.
- frame_start = pix_valid with x=0 and y=0. frame_cnt increments on each frame_start and wraps 0xFFFF→0.
- locked=1 exactly while in LOCKED.

## Timing
- Latency: one clk_50. A sample taken at edge N with pix_en=1 appears on the outputs after edge N+1, held for one cycle.
- pix_valid, frame_start, h_err, v_err are single-cycle pulses. The outputs x_out, y_out and rgb_out hold their values between pulses.
- Reset values: x_out=0, y_out=0, rgb_out=0, pix_valid=0, frame_start=0, locked=0, h_err=0, v_err=0, frame_cnt=0, FSM=SEARCH, counters=0, edge history = not asserted.
- Reset mid-frame: all outputs return to their reset values on the cycle after reset is sampled. Relock requires a VS edge followed by one full clean frame.
- Minimum lock time from a clean stream: the first VS edge plus one frame. frame_start then fires on the following frame.

## Structure
- Shared package vga_timing_pkg holds:
  - the 640x480 timing constants (defaults for the parameters above), H_TOTAL and V_TOTAL;
  - typedef enum {SEARCH, ALIGN, LOCKED} vga_lock_state_t.
- Sub-module vga_edge_detect: registered sync-edge detector gated by pix_en, parameterised by SYNC_ACTIVE. It is instantiated twice, once for HS and once for VS.
- Target: 150–250 lines of RTL for the top module plus the sub-module.

## Test plan
- Clean stream from the bench timing generator, reset released:
  - locked rises at the end of the first full frame after the first VS edge.
  - The next frame gives exactly 307200 pix_valid pulses, x/y matching the generator, and frame_start once with frame_cnt=1.
- RGB tracking: generator drives rgb={y[3:0],x[7:0]}; rgb_out equals {y_out[3:0],x_out[7:0]} on every pix_valid.
- While locked, one line shortened to 799 pixels:
  - one h_err pulse, locked falls, no pix_valid until relock;
  - relock after the next VS edge plus one clean frame.
- While locked, a 526-line frame: one v_err pulse at the late wrap, FSM returns to SEARCH.
- While locked, HS held deasserted for 1000 pixels: h_err when the 800th sample passes with no HS edge; no further h_err while in SEARCH.
- Reset asserted at output pixel x=100, y=200: next cycle all outputs are 0 and locked=0; after release, lock behaviour is identical to the first scenario.
